// File: rtl/sync_peak_finder_if.sv
// -----------------------------------------------------------------------------
// sync_peak_finder_if
//
// Bundles the magnitude stream, threshold and peak report of sync_peak_finder.
//
// Signals:
//   mag_in    [MAG_W-1:0]  unsigned magnitude sample
//   mag_val                mag_in valid this cycle
//   thresh    [MAG_W-1:0]  unsigned trigger threshold
//   peak_val               one-cycle report pulse
//   peak_mag  [MAG_W-1:0]  maximum magnitude found in the window
//   peak_idx  [IDX_W-1:0]  offset of the maximum from the trigger sample
//   busy                   finder is not idle
//   above_cnt [IDX_W:0]    window samples above threshold (SPF_ABOVE_CNT_EN only)
//
// Modports:
//   master  upstream side: drives the stream and threshold, receives the report
//   slave   the peak finder itself
//
// Optional feature macro: SPF_ABOVE_CNT_EN adds above_cnt.
// -----------------------------------------------------------------------------
interface sync_peak_finder_if #(
    parameter int MAG_W = 17,
    parameter int IDX_W = 6
);
    logic [MAG_W-1:0] mag_in;
    logic             mag_val;
    logic [MAG_W-1:0] thresh;
    logic             peak_val;
    logic [MAG_W-1:0] peak_mag;
    logic [IDX_W-1:0] peak_idx;
    logic             busy;
`ifdef SPF_ABOVE_CNT_EN
    logic [IDX_W:0]   above_cnt;
`endif

    modport master (
        output mag_in, mag_val, thresh,
        input  peak_val, peak_mag, peak_idx, busy
`ifdef SPF_ABOVE_CNT_EN
        , input above_cnt
`endif
    );

    modport slave (
        input  mag_in, mag_val, thresh,
        output peak_val, peak_mag, peak_idx, busy
`ifdef SPF_ABOVE_CNT_EN
        , output above_cnt
`endif
    );
endinterface

// File: rtl/sync_peak_finder.sv
// -----------------------------------------------------------------------------
// sync_peak_finder
//
// Arms when a magnitude sample strictly exceeds a programmable threshold, then
// searches a window of WIN valid samples (trigger included) for the maximum
// and reports the peak magnitude and its offset from the trigger sample.
// After each report, HOLDOFF valid samples are ignored before re-arming.
//
// Ports:
//   clk   clock
//   rst   synchronous, active-high reset
//   bus   sync_peak_finder_if.slave
//           in : mag_in, mag_val, thresh
//           out: peak_val, peak_mag, peak_idx, busy [, above_cnt]
//
// Optional feature macro: SPF_ABOVE_CNT_EN
//   Adds above_cnt: number of window samples strictly above the latched
//   threshold, registered alongside peak_mag at the report edge.
// -----------------------------------------------------------------------------
module sync_peak_finder #(
    parameter int MAG_W   = 17,
    parameter int WIN     = 64,
    parameter int IDX_W   = 6,
    parameter int HOLDOFF = 16
) (
    input  logic              clk,
    input  logic              rst,
    sync_peak_finder_if.slave bus
);
    localparam int CNT_W  = IDX_W + 1;
    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WIN - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        REPORT,
        HOLD
    } state_t;

    state_t           state_q,    state_nx;
    logic [MAG_W-1:0] max_q,      max_nx;
    logic [IDX_W-1:0] idx_q,      idx_nx;
    logic [CNT_W-1:0] cnt_q,      cnt_nx;
    logic [MAG_W-1:0] thresh_q,   thresh_nx;
    logic [HOLD_W-1:0] hold_q,    hold_nx;
    logic             peak_val_q, peak_val_nx;
    logic [MAG_W-1:0] peak_mag_q, peak_mag_nx;
    logic [IDX_W-1:0] peak_idx_q, peak_idx_nx;
`ifdef SPF_ABOVE_CNT_EN
    logic [CNT_W-1:0] above_q,     above_nx;      // running count in window
    logic [CNT_W-1:0] above_out_q, above_out_nx;  // reported count
`endif

    // Next-state and datapath logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_nx    = state_q;
        max_nx      = max_q;
        idx_nx      = idx_q;
        cnt_nx      = cnt_q;
        thresh_nx   = thresh_q;
        hold_nx     = hold_q;
        peak_val_nx = 1'b0;
        peak_mag_nx = peak_mag_q;
        peak_idx_nx = peak_idx_q;
`ifdef SPF_ABOVE_CNT_EN
        above_nx     = above_q;
        above_out_nx = above_out_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.mag_val && (bus.mag_in > bus.thresh)) begin
                    state_nx  = SEARCH;
                    max_nx    = bus.mag_in;
                    idx_nx    = '0;
                    cnt_nx    = CNT_ONE;
                    thresh_nx = bus.thresh;
`ifdef SPF_ABOVE_CNT_EN
                    above_nx  = CNT_ONE;   // the trigger itself is above threshold
`endif
                end
            end

            SEARCH: begin
                if (bus.mag_val) begin
                    // Strict compare: on a tie the earlier sample keeps the peak.
                    if (bus.mag_in > max_q) begin
                        max_nx = bus.mag_in;
                        idx_nx = cnt_q[IDX_W-1:0];   // cnt_q < WIN here, fits IDX_W
                    end
`ifdef SPF_ABOVE_CNT_EN
                    if (bus.mag_in > thresh_q) begin
                        above_nx = above_q + CNT_ONE;
                    end
`endif
                    cnt_nx = cnt_q + CNT_ONE;
                    // This sample completes the window; its compare is already
                    // folded into max_nx/idx_nx, so report those directly.
                    if (cnt_q == CNT_LAST) begin
                        state_nx    = REPORT;
                        peak_val_nx = 1'b1;
                        peak_mag_nx = max_nx;
                        peak_idx_nx = idx_nx;
`ifdef SPF_ABOVE_CNT_EN
                        above_out_nx = above_nx;
`endif
                    end
                end
            end

            REPORT: begin
                // Any sample arriving in this cycle is dropped.
                hold_nx  = '0;
                state_nx = (HOLDOFF == 0) ? IDLE : HOLD;
            end

            HOLD: begin
                if (bus.mag_val) begin
                    if (hold_q == HOLD_LAST) begin
                        state_nx = IDLE;
                    end else begin
                        hold_nx = hold_q + HOLD_ONE;
                    end
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q    <= IDLE;
            max_q      <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            thresh_q   <= '0;
            hold_q     <= '0;
            peak_val_q <= 1'b0;
            peak_mag_q <= '0;
            peak_idx_q <= '0;
`ifdef SPF_ABOVE_CNT_EN
            above_q     <= '0;
            above_out_q <= '0;
`endif
        end else begin
            state_q    <= state_nx;
            max_q      <= max_nx;
            idx_q      <= idx_nx;
            cnt_q      <= cnt_nx;
            thresh_q   <= thresh_nx;
            hold_q     <= hold_nx;
            peak_val_q <= peak_val_nx;
            peak_mag_q <= peak_mag_nx;
            peak_idx_q <= peak_idx_nx;
`ifdef SPF_ABOVE_CNT_EN
            above_q     <= above_nx;
            above_out_q <= above_out_nx;
`endif
        end
    end

    assign bus.peak_val = peak_val_q;
    assign bus.peak_mag = peak_mag_q;
    assign bus.peak_idx = peak_idx_q;
    assign bus.busy     = (state_q != IDLE);
`ifdef SPF_ABOVE_CNT_EN
    assign bus.above_cnt = above_out_q;
`endif

endmodule

// File: tb/tb_sync_peak_finder.sv
// -----------------------------------------------------------------------------
// tb_sync_peak_finder
//
// Directed bench for sync_peak_finder. Two instances with WIN=8 share one
// stimulus stream: u_h4 with HOLDOFF=4 and u_h0 with HOLDOFF=0.
// Honors SPF_ABOVE_CNT_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_sync_peak_finder;
    localparam int MAG_W = 17;
    localparam int WIN   = 8;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst;
    logic [MAG_W-1:0] mag_in;
    logic             mag_val;
    logic [MAG_W-1:0] thresh;

    int n_checks = 0;
    int n_pass   = 0;

    sync_peak_finder_if #(.MAG_W(MAG_W), .IDX_W(IDX_W)) bus_h4 ();
    sync_peak_finder_if #(.MAG_W(MAG_W), .IDX_W(IDX_W)) bus_h0 ();

    assign bus_h4.mag_in  = mag_in;
    assign bus_h4.mag_val = mag_val;
    assign bus_h4.thresh  = thresh;
    assign bus_h0.mag_in  = mag_in;
    assign bus_h0.mag_val = mag_val;
    assign bus_h0.thresh  = thresh;

    sync_peak_finder #(.MAG_W(MAG_W), .WIN(WIN), .IDX_W(IDX_W), .HOLDOFF(4)) u_h4 (
        .clk (clk),
        .rst (rst),
        .bus (bus_h4)
    );

    sync_peak_finder #(.MAG_W(MAG_W), .WIN(WIN), .IDX_W(IDX_W), .HOLDOFF(0)) u_h0 (
        .clk (clk),
        .rst (rst),
        .bus (bus_h0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of input, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic [MAG_W-1:0] m);
        mag_val = v;
        mag_in  = m;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Feed HOLDOFF(=4) valid zeros, enough to release u_h4 from HOLD.
    task automatic flush_hold();
        for (int i = 0; i < 4; i++) step(1'b1, '0);
    endtask

    logic [MAG_W-1:0] basic_s [10] = '{50, 50, 120, 130, 200, 150, 90, 90, 90, 90};
    logic [MAG_W-1:0] tie_s   [8]  = '{150, 300, 120, 110, 110, 300, 110, 110};

    initial begin
        rst     = 1'b1;
        mag_val = 1'b1;
        mag_in  = 17'h1FFFF;
        thresh  = '0;

        // ---- Reset held with a full-scale valid stream ----
        for (int i = 0; i < 3; i++) step(1'b1, 17'h1FFFF);
        check("rst_peak_val", bus_h4.peak_val, 0);
        check("rst_peak_mag", bus_h4.peak_mag, 0);
        check("rst_peak_idx", bus_h4.peak_idx, 0);
        check("rst_busy_h4",  bus_h4.busy, 0);
        check("rst_busy_h0",  bus_h0.busy, 0);
        rst = 1'b0;

        // ---- First sample after release triggers; full-scale window ----
        step(1'b1, 17'h1FFFF);
        check("fs_busy_h4", bus_h4.busy, 1);
        check("fs_busy_h0", bus_h0.busy, 1);
        for (int i = 0; i < 6; i++) step(1'b1, 17'd5);
        check("fs_no_early_pulse", bus_h4.peak_val, 0);
        step(1'b1, 17'd5);
        check("fs_peak_val", bus_h4.peak_val, 1);
        check("fs_peak_mag", bus_h4.peak_mag, 32'h1FFFF);
        check("fs_peak_idx", bus_h4.peak_idx, 0);
        check("fs_peak_mag_h0", bus_h0.peak_mag, 32'h1FFFF);
`ifdef SPF_ABOVE_CNT_EN
        check("fs_above_cnt", bus_h4.above_cnt, 8);
`endif
        // REPORT cycle: this valid sample must be dropped.
        thresh = 17'd100;
        step(1'b1, '0);
        check("fs_pulse_one_cycle", bus_h4.peak_val, 0);
        check("fs_h4_hold_busy", bus_h4.busy, 1);
        check("fs_h0_idle", bus_h0.busy, 0);
        for (int i = 0; i < 3; i++) step(1'b1, '0);
        check("hold_3_still_busy", bus_h4.busy, 1);
        step(1'b1, '0);
        check("hold_4_idle", bus_h4.busy, 0);

        // ---- Basic peak ----
        step(1'b1, basic_s[0]);
        step(1'b1, basic_s[1]);
        check("basic_below_thresh", bus_h4.busy, 0);
        step(1'b1, basic_s[2]);
        check("basic_trigger_busy", bus_h4.busy, 1);
        for (int i = 3; i < 9; i++) step(1'b1, basic_s[i]);
        check("basic_no_early_pulse", bus_h4.peak_val, 0);
        step(1'b1, basic_s[9]);
        check("basic_peak_val", bus_h4.peak_val, 1);
        check("basic_peak_mag", bus_h4.peak_mag, 200);
        check("basic_peak_idx", bus_h4.peak_idx, 2);
        check("basic_peak_mag_h0", bus_h0.peak_mag, 200);
        check("basic_peak_idx_h0", bus_h0.peak_idx, 2);
`ifdef SPF_ABOVE_CNT_EN
        check("basic_above_cnt", bus_h4.above_cnt, 4);
`endif
        step(1'b0, '0);
        check("basic_pulse_end", bus_h4.peak_val, 0);
        check("basic_mag_held", bus_h4.peak_mag, 200);

        // ---- Holdoff: u_h4 in HOLD, u_h0 idle ----
        step(1'b1, 17'd500);
        check("ho0_first_triggers", bus_h0.busy, 1);
        check("ho4_first_held", bus_h4.busy, 1);
        for (int i = 0; i < 3; i++) step(1'b1, 17'd500);
        check("ho4_fourth_ends_hold", bus_h4.busy, 0);
        step(1'b1, 17'd500);
        check("ho4_fifth_triggers", bus_h4.busy, 1);
        step(1'b1, 17'd600);
        step(1'b1, 17'd10);
        step(1'b1, 17'd10);
        check("ho0_peak_val", bus_h0.peak_val, 1);
        check("ho0_peak_mag", bus_h0.peak_mag, 600);
        check("ho0_peak_idx", bus_h0.peak_idx, 5);
        check("ho4_not_yet", bus_h4.peak_val, 0);
`ifdef SPF_ABOVE_CNT_EN
        check("ho0_above_cnt", bus_h0.above_cnt, 6);
`endif
        step(1'b1, 17'd10);
        check("ho0_pulse_end", bus_h0.peak_val, 0);
        for (int i = 0; i < 2; i++) step(1'b1, 17'd10);
        check("ho4_no_early_pulse", bus_h4.peak_val, 0);
        step(1'b1, 17'd10);
        check("ho4_peak_val", bus_h4.peak_val, 1);
        check("ho4_peak_mag", bus_h4.peak_mag, 600);
        check("ho4_peak_idx", bus_h4.peak_idx, 1);
        check("ho0_stays_idle", bus_h0.busy, 0);
`ifdef SPF_ABOVE_CNT_EN
        check("ho4_above_cnt", bus_h4.above_cnt, 2);
`endif
        step(1'b0, '0);
        flush_hold();

        // ---- Tie: earliest maximum wins ----
        for (int i = 0; i < 8; i++) step(1'b1, tie_s[i]);
        check("tie_peak_val", bus_h4.peak_val, 1);
        check("tie_peak_mag", bus_h4.peak_mag, 300);
        check("tie_peak_idx", bus_h4.peak_idx, 1);
        check("tie_peak_idx_h0", bus_h0.peak_idx, 1);
`ifdef SPF_ABOVE_CNT_EN
        check("tie_above_cnt", bus_h4.above_cnt, 8);
`endif
        step(1'b0, '0);
        flush_hold();

        // ---- Gaps: three idle cycles between samples ----
        for (int i = 0; i < 10; i++) begin
            step(1'b1, basic_s[i]);
            if (i < 9) begin
                for (int g = 0; g < 3; g++) step(1'b0, 17'd999);
            end
            if (i == 8) check("gap_no_early_pulse", bus_h4.peak_val, 0);
        end
        check("gap_peak_val", bus_h4.peak_val, 1);
        check("gap_peak_mag", bus_h4.peak_mag, 200);
        check("gap_peak_idx", bus_h4.peak_idx, 2);
        check("gap_peak_val_h0", bus_h0.peak_val, 1);
`ifdef SPF_ABOVE_CNT_EN
        check("gap_above_cnt", bus_h4.above_cnt, 4);
`endif
        step(1'b0, '0);
        flush_hold();

        // ---- Reset mid-search ----
        for (int i = 2; i < 7; i++) step(1'b1, basic_s[i]);
        check("mid_busy_before_rst", bus_h4.busy, 1);
        rst = 1'b1;
        step(1'b1, 17'd300);
        rst = 1'b0;
        check("mid_rst_peak_val", bus_h4.peak_val, 0);
        check("mid_rst_peak_mag", bus_h4.peak_mag, 0);
        check("mid_rst_peak_idx", bus_h4.peak_idx, 0);
        check("mid_rst_busy", bus_h4.busy, 0);
        check("mid_rst_busy_h0", bus_h0.busy, 0);
        step(1'b1, 17'd100);
        check("equal_thresh_no_trigger", bus_h4.busy, 0);
        for (int i = 0; i < 7; i++) step(1'b1, 17'd101);
        check("post_rst_no_early_pulse", bus_h4.peak_val, 0);
        step(1'b1, 17'd109);
        check("post_rst_peak_val", bus_h4.peak_val, 1);
        check("post_rst_peak_mag", bus_h4.peak_mag, 109);
        check("post_rst_peak_idx", bus_h4.peak_idx, 7);
        check("post_rst_peak_idx_h0", bus_h0.peak_idx, 7);
`ifdef SPF_ABOVE_CNT_EN
        check("post_rst_above_cnt", bus_h4.above_cnt, 8);
`endif
        step(1'b0, '0);
        check("post_rst_pulse_end", bus_h4.peak_val, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
